// File: rtl/park_pkg.sv
// Shared sizing for the parking-occupancy block.
// Counter width covers 0..15 spots per floor; floor index addresses up to four floors.
package park_pkg;
    localparam int FLOORS_DEF          = 4;
    localparam int SPOTS_PER_FLOOR_DEF = 4;
    localparam int CNT_W               = 4;
    localparam int FLOOR_W             = 2;
endpackage

// File: rtl/floor_counter.sv
// Saturating up/down occupancy counter for one floor; updates on the edge after inc/dec.
// No backpressure: inc when full, dec when empty, or both together are dropped.
module floor_counter
    import park_pkg::*;
#(
    parameter int SPOTS = SPOTS_PER_FLOOR_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    assign full  = (count == CNT_W'(SPOTS));
    assign empty = (count == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && !dec && !full) begin
            count <= count + 1'b1;
        end else if (dec && !inc && !empty) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/park_system.sv
// Multi-floor parking occupancy: fills lowest non-full floor, drains highest non-empty floor.
// Outputs follow requests one edge later; no backpressure, requests beyond capacity are dropped.
module park_system
    import park_pkg::*;
#(
    parameter int FLOORS          = FLOORS_DEF,
    parameter int SPOTS_PER_FLOOR = SPOTS_PER_FLOOR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               car_in,
    input  logic               car_out,
    output logic [CNT_W-1:0]   free_spots,
    output logic [FLOOR_W-1:0] current_floor,
    output logic               parking_full
);

    logic [CNT_W-1:0]   count [FLOORS];
    logic [FLOORS-1:0]  full;
    logic [FLOORS-1:0]  empty;
    logic [FLOOR_W-1:0] fill_idx;
    logic [FLOOR_W-1:0] drain_idx;
    logic               fill_found;
    logic               drain_found;
    logic               any_car;
    logic               inc_en;
    logic               dec_en;

    // Priority search: first non-full from the bottom, first non-empty from the top.
    always_comb begin
        fill_idx    = FLOOR_W'(FLOORS - 1);
        fill_found  = 1'b0;
        drain_idx   = '0;
        drain_found = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (!fill_found && !full[i]) begin
                fill_idx   = FLOOR_W'(i);
                fill_found = 1'b1;
            end
        end
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (!drain_found && !empty[i]) begin
                drain_idx   = FLOOR_W'(i);
                drain_found = 1'b1;
            end
        end
    end

    assign parking_full = &full;
    assign any_car      = ~(&empty);
    assign inc_en       = car_in  && !car_out && !parking_full;
    assign dec_en       = car_out && !car_in  && any_car;

    for (genvar g = 0; g < FLOORS; g++) begin : g_floor
        floor_counter #(
            .SPOTS (SPOTS_PER_FLOOR)
        ) u_floor_counter (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_en && (fill_idx  == FLOOR_W'(g))),
            .dec   (dec_en && (drain_idx == FLOOR_W'(g))),
            .count (count[g]),
            .full  (full[g]),
            .empty (empty[g])
        );
    end

    // When the facility is full the selected floor is the top one, itself full, so this yields 0.
    assign current_floor = fill_idx;
    assign free_spots    = CNT_W'(SPOTS_PER_FLOOR) - count[fill_idx];

endmodule

// File: tb/tb_park_system.sv
// Scoreboard bench for park_system: a total-occupancy model predicts outputs after each edge.
module tb_park_system;

    typedef struct packed {
        logic [3:0] fs;
        logic [1:0] cf;
        logic       pf;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       car_in;
    logic       car_out;
    logic [3:0] free_spots;
    logic [1:0] current_floor;
    logic       parking_full;

    int   total;
    int   bad;
    int   occ;
    exp_t sb[$];
    exp_t exp_v;
    exp_t got;

    park_system dut (
        .clk           (clk),
        .rst           (rst),
        .car_in        (car_in),
        .car_out       (car_out),
        .free_spots    (free_spots),
        .current_floor (current_floor),
        .parking_full  (parking_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fill order is strictly bottom-up and drain strictly top-down, so total occupancy fixes the floor pattern.
    function automatic exp_t model(input int t);
        exp_t e;
        if (t >= 16) begin
            e.fs = 4'd0;
            e.cf = 2'd3;
            e.pf = 1'b1;
        end else begin
            e.fs = 4'(4 - (t % 4));
            e.cf = 2'(t / 4);
            e.pf = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle of requests, predict, and advance to just after the edge.
    task automatic step(input logic ci, input logic co);
        car_in  = ci;
        car_out = co;
        if (ci && !co && occ < 16)
            occ++;
        else if (co && !ci && occ > 0)
            occ--;
        sb.push_back(model(occ));
        @(posedge clk);
        #1;
        car_in  = 1'b0;
        car_out = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        occ = 0;
        #3;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        car_in  = 1'b0;
        car_out = 1'b0;
        occ     = 0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(model(0));
        exp_v = sb.pop_front();
        got   = {free_spots, current_floor, parking_full};
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL reset_hold: got fs=%0d cf=%0d pf=%0d want fs=%0d cf=%0d pf=%0d",
                     got.fs, got.cf, got.pf, exp_v.fs, exp_v.cf, exp_v.pf);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, 1'b0);
        exp_v = sb.pop_front();
        got   = {free_spots, current_floor, parking_full};
        total++;
        if (got !== exp_v || got !== exp_t'({4'd4, 2'd0, 1'b0})) begin
            bad++;
            $display("FAIL reset_release: got fs=%0d cf=%0d pf=%0d want fs=4 cf=0 pf=0",
                     got.fs, got.cf, got.pf);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0);
            exp_v = sb.pop_front();
            got   = {free_spots, current_floor, parking_full};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL fill_%0d: got fs=%0d cf=%0d pf=%0d want fs=%0d cf=%0d pf=%0d",
                         i, got.fs, got.cf, got.pf, exp_v.fs, exp_v.cf, exp_v.pf);
            end
        end
        total++;
        if (got !== exp_t'({4'd2, 2'd3, 1'b0})) begin
            bad++;
            $display("FAIL fill_end: got fs=%0d cf=%0d pf=%0d want fs=2 cf=3 pf=0",
                     got.fs, got.cf, got.pf);
        end
    endtask

    task automatic test_depart();
        for (int i = 0; i < 3; i++) begin
            step(i < 2 ? 1'b0 : 1'b1, i < 2 ? 1'b1 : 1'b0);
            exp_v = sb.pop_front();
            got   = {free_spots, current_floor, parking_full};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL depart_%0d: got fs=%0d cf=%0d pf=%0d want fs=%0d cf=%0d pf=%0d",
                         i, got.fs, got.cf, got.pf, exp_v.fs, exp_v.cf, exp_v.pf);
            end
        end
        total++;
        if (got !== exp_t'({4'd3, 2'd3, 1'b0})) begin
            bad++;
            $display("FAIL depart_end: got fs=%0d cf=%0d pf=%0d want fs=3 cf=3 pf=0",
                     got.fs, got.cf, got.pf);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            exp_v = sb.pop_front();
            got   = {free_spots, current_floor, parking_full};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL sat_%0d: got fs=%0d cf=%0d pf=%0d want fs=%0d cf=%0d pf=%0d",
                         i, got.fs, got.cf, got.pf, exp_v.fs, exp_v.cf, exp_v.pf);
            end
        end
        // Both requests while full must leave the facility full.
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            exp_v = sb.pop_front();
            if (i == 0) begin
                total++;
                if (exp_v !== exp_t'({4'd0, 2'd3, 1'b1})) begin
                    bad++;
                    $display("FAIL sat_model: want fs=0 cf=3 pf=1 got fs=%0d cf=%0d pf=%0d",
                             exp_v.fs, exp_v.cf, exp_v.pf);
                end
            end
        end
        got = {free_spots, current_floor, parking_full};
        total++;
        if (got !== exp_v || got !== exp_t'({4'd1, 2'd3, 1'b0})) begin
            bad++;
            $display("FAIL sat_depart: got fs=%0d cf=%0d pf=%0d want fs=1 cf=3 pf=0",
                     got.fs, got.cf, got.pf);
        end
    endtask

    task automatic test_empty_simul();
        logic ci_tab [12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
        logic co_tab [12] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(ci_tab[i], co_tab[i]);
            exp_v = sb.pop_front();
            got   = {free_spots, current_floor, parking_full};
            total++;
            if (got !== exp_v) begin
                bad++;
                $display("FAIL simul_%0d: got fs=%0d cf=%0d pf=%0d want fs=%0d cf=%0d pf=%0d",
                         i, got.fs, got.cf, got.pf, exp_v.fs, exp_v.cf, exp_v.pf);
            end
        end
        total++;
        if (got !== exp_t'({4'd4, 2'd1, 1'b0})) begin
            bad++;
            $display("FAIL simul_end: got fs=%0d cf=%0d pf=%0d want fs=4 cf=1 pf=0",
                     got.fs, got.cf, got.pf);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            exp_v = sb.pop_front();
        end
        got = {free_spots, current_floor, parking_full};
        total++;
        if (got !== exp_v || got !== exp_t'({4'd2, 2'd2, 1'b0})) begin
            bad++;
            $display("FAIL async_pre: got fs=%0d cf=%0d pf=%0d want fs=2 cf=2 pf=0",
                     got.fs, got.cf, got.pf);
        end
        #2;
        rst = 1'b0;
        occ = 0;
        #1;
        sb.push_back(model(occ));
        exp_v = sb.pop_front();
        got   = {free_spots, current_floor, parking_full};
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL async_clear: got fs=%0d cf=%0d pf=%0d want fs=%0d cf=%0d pf=%0d",
                     got.fs, got.cf, got.pf, exp_v.fs, exp_v.cf, exp_v.pf);
        end
        car_in = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back(model(occ));
        exp_v = sb.pop_front();
        got   = {free_spots, current_floor, parking_full};
        total++;
        if (got !== exp_v) begin
            bad++;
            $display("FAIL async_ignore: got fs=%0d cf=%0d pf=%0d want fs=%0d cf=%0d pf=%0d",
                     got.fs, got.cf, got.pf, exp_v.fs, exp_v.cf, exp_v.pf);
        end
        car_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step(1'b1, 1'b0);
        exp_v = sb.pop_front();
        got   = {free_spots, current_floor, parking_full};
        total++;
        if (got !== exp_v || got !== exp_t'({4'd3, 2'd0, 1'b0})) begin
            bad++;
            $display("FAIL async_first: got fs=%0d cf=%0d pf=%0d want fs=3 cf=0 pf=0",
                     got.fs, got.cf, got.pf);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        occ     = 0;
        rst     = 1'b0;
        car_in  = 1'b0;
        car_out = 1'b0;
        test_reset();
        test_fill();
        test_depart();
        test_saturation();
        test_empty_simul();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
